mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit with its own HI/LO architectural registers.
- Feeds the HI/LO read value that the EX/MEM register carries forward.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and models fixed multi-cycle latency with a busy flag; hazard logic uses that flag to stall MDU-dependent instructions in D.
- Serves MFHI/MFLO reads combinationally.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  op qualifier; one cycle per E-stage instruction
- op  in  3  operation code (package constants)
- src_a  in  32  rs operand (forwarded value)
- src_b  in  32  rt operand (forwarded value)
- rd_sel  in  1  0 = read LO, 1 = read HI
- busy  out  1  computation in progress
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  combinational mux of hi/lo by rd_sel; goes to EX/MEM hilo field

Behaviour:
- Reset (sync, clk edge with reset=1):
  - hi = 0, lo = 0, busy = 0, counter = 0, pending result discarded.
  - Applies even mid-operation; no late HI/LO write afterwards.
- States: IDLE, RUN. busy = (state == RUN).
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Operands and op are latched and the 64-bit result is computed at this edge.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy is high for exactly N cycles, starting the cycle after start.
- RUN: counter decrements each cycle. At the edge where counter == 1, HI/LO take the latched result, go to IDLE, busy falls.
  - New HI/LO are visible in the first cycle busy=0.
  - Start at cycle t gives busy in t+1..t+N and new hi/lo from t+N+1.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo = 0x80000000, hi = 0.
  - Divisor 0 (DIV or DIVU): full DIV_CYCLES busy; hi/lo unchanged at completion.
- MTHI/MTLO in IDLE with start=1: hi (or lo) = src_a at that edge; busy stays 0. This is single-cycle.
- start=1 while busy: ignored entirely, no state change. The stall unit guarantees this never happens in a correct pipeline; the bench checks it anyway.
- start=1 with op NONE or an unknown code: no effect.
- Simultaneous completion and start in the same cycle: the start is ignored because busy is still 1 in that cycle.
- rd_data reflects the registered hi/lo only. While busy it returns the old value; the stall unit prevents MFHI/MFLO from consuming it then.
- No enable or flush input. The E stage issues start only for a valid, unflushed instruction, so a bubble never starts an op.

Decomposition:
- Shared package mdu_pkg:
  - Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Default cycle constants: 5 and 10.
  - Stall decode uses the same codes.
- One sub-module, mdu_calc: purely combinational. Takes op, a, b and produces the 64-bit {hi, lo} result plus a div_by_zero flag.
- The top level holds the FSM, counter, result latch and HI/LO registers.

Test Plan:
1. MULT, a=0xFFFFFFFE (-2), b=3, start at t -> busy in t+1..t+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at t+6.
2. MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
3. DIV, a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU, a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
4. MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> busy never rises; rd_sel=1 gives 0x12345678 and rd_sel=0 gives 0x9ABCDEF0 on the following cycles.
5. Start DIV, assert MTLO start at busy cycle 3, then reset at busy cycle 6 -> MTLO ignored; after reset busy=0, hi=lo=0 and stay 0 past the original completion time.
6. MULT with MULT_CYCLES=1 and DIV_CYCLES=1 overrides -> busy exactly 1 cycle; back-to-back ops issued as soon as busy falls complete correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies
// and decode helpers also used by the stall logic in D.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for several cycles and set busy.
  function automatic logic is_long_op(input logic [2:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply / divide datapath producing the {hi, lo} pair
// for the requested op, plus a flag for a zero divisor.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division is done on magnitudes so 0x80000000 / -1 never overflows;
  // the quotient magnitude 0x80000000 is already the wrapped answer.
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_s;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] div_u;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b[31] ? (32'd0 - b) : b;
  assign div_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / div_s;
  assign r_mag = a_mag % div_s;
  assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;

  assign div_u = (b == 32'd0) ? 32'd1 : b;
  assign q_u   = a / div_u;
  assign r_u   = a % div_u;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result      = {r_s, q_s};
        div_by_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        result      = {r_u, q_u};
        div_by_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: fixed-latency busy model around a
// combinational datapath, owning the architectural HI/LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t       state_q;
  mdu_state_t       state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] op_cycles;
  logic [63:0]      res_q;
  logic             commit_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [63:0]      calc_result;
  logic             calc_div_by_zero;
  logic             idle_start;
  logic             launch;
  logic             finish;

  mdu_calc u_calc (
    .op          (op),
    .a           (src_a),
    .b           (src_b),
    .result      (calc_result),
    .div_by_zero (calc_div_by_zero)
  );

  // Anything arriving while RUN is dropped, including a start in the
  // completion cycle.
  assign idle_start = (state_q == ST_IDLE) && start;
  assign launch     = idle_start && is_long_op(op);
  assign finish     = (state_q == ST_RUN) && (count_q == CNT_W'(1));
  assign op_cycles  = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_RUN;
      ST_RUN:  if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_RUN);
    rd_data = rd_sel ? hi_q : lo_q;
  end

  // The result is captured at launch; commit_q is cleared for a zero
  // divisor so completion leaves HI/LO untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      res_q    <= 64'd0;
      commit_q <= 1'b0;
    end else if (launch) begin
      count_q  <= op_cycles;
      res_q    <= calc_result;
      commit_q <= ~calc_div_by_zero;
    end else if (state_q == ST_RUN) begin
      count_q  <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (finish) begin
      if (commit_q) {hi_q, lo_q} <= res_q;
    end else if (idle_start) begin
      if (op == MD_MTHI) hi_q <= src_a;
      if (op == MD_MTLO) lo_q <= src_a;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: default-latency instance plus a
// single-cycle-latency instance, expected values computed by hand.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  logic        f_start;
  logic [2:0]  f_op;
  logic [31:0] f_src_a;
  logic [31:0] f_src_b;
  logic        f_busy;
  logic [31:0] f_hi;
  logic [31:0] f_lo;
  logic [31:0] f_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  mult_div_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut_fast (
    .clk     (clk),
    .reset   (reset),
    .start   (f_start),
    .op      (f_op),
    .src_a   (f_src_a),
    .src_b   (f_src_b),
    .rd_sel  (1'b0),
    .busy    (f_busy),
    .hi      (f_hi),
    .lo      (f_lo),
    .rd_data (f_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for one cycle; returns in the cycle after the start.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = MD_NONE;
  endtask

  // Called in the first busy cycle: busy must hold for exactly n cycles.
  task automatic expect_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = MD_NONE;
    src_a   = 32'd0;
    src_b   = 32'd0;
    rd_sel  = 1'b0;
    f_start = 1'b0;
    f_op    = MD_NONE;
    f_src_a = 32'd0;
    f_src_b = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset rd_data", rd_data, 32'd0);

    // MULT -2 * 3, with an MTHI offered in the completion cycle.
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("mult busy", {31'd0, busy}, 32'd1);
      check("mult old lo", lo, 32'd0);
      tick();
    end
    check("mult last busy", {31'd0, busy}, 32'd1);
    issue(MD_MTHI, 32'h55555555, 32'd0);
    check("mult busy fall", {31'd0, busy}, 32'd0);
    check("mult hi", hi, 32'hFFFFFFFF);
    check("mult lo", lo, 32'hFFFFFFFA);
    tick();
    check("completion start ignored busy", {31'd0, busy}, 32'd0);
    check("completion start ignored hi", hi, 32'hFFFFFFFF);

    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_busy("multu", 5);
    check("multu hi", hi, 32'hFFFFFFFE);
    check("multu lo", lo, 32'h00000001);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    expect_busy("div", 10);
    check("div hi", hi, 32'hFFFFFFFF);
    check("div lo", lo, 32'hFFFFFFFD);

    issue(MD_DIVU, 32'd7, 32'd0);
    expect_busy("divu by zero", 10);
    check("divu by zero hi", hi, 32'hFFFFFFFF);
    check("divu by zero lo", lo, 32'hFFFFFFFD);

    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    expect_busy("div overflow", 10);
    check("div overflow hi", hi, 32'h00000000);
    check("div overflow lo", lo, 32'h80000000);

    issue(MD_DIVU, 32'd100, 32'd7);
    expect_busy("divu", 10);
    check("divu hi", hi, 32'd2);
    check("divu lo", lo, 32'd14);

    // Unknown and NONE ops have no effect.
    issue(3'd7, 32'hDEADBEEF, 32'd1);
    check("unknown op busy", {31'd0, busy}, 32'd0);
    issue(MD_NONE, 32'hDEADBEEF, 32'd1);
    check("none op busy", {31'd0, busy}, 32'd0);
    check("no-op hi", hi, 32'd2);
    check("no-op lo", lo, 32'd14);

    // MTHI then MTLO back to back.
    issue(MD_MTHI, 32'h12345678, 32'd0);
    check("mthi busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'h9ABCDEF0, 32'd0);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    rd_sel = 1'b1;
    #1;
    check("rd_data hi", rd_data, 32'h12345678);
    tick();
    rd_sel = 1'b0;
    #1;
    check("rd_data lo", rd_data, 32'h9ABCDEF0);
    check("mtx busy stays low", {31'd0, busy}, 32'd0);

    // DIV interrupted: MTLO at busy cycle 3 dropped, reset at busy cycle 6.
    issue(MD_DIV, 32'd100, 32'd7);
    tick();
    tick();
    check("abort busy cycle 3", {31'd0, busy}, 32'd1);
    issue(MD_MTLO, 32'hDEADBEEF, 32'd0);
    check("busy start ignored busy", {31'd0, busy}, 32'd1);
    check("busy start ignored lo", lo, 32'h9ABCDEF0);
    rd_sel = 1'b1;
    #1;
    check("rd_data old hi while busy", rd_data, 32'h12345678);
    rd_sel = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort reset busy", {31'd0, busy}, 32'd0);
    check("abort reset hi", hi, 32'd0);
    check("abort reset lo", lo, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort no late write hi", hi, 32'd0);
      check("abort no late write lo", lo, 32'd0);
      check("abort no late busy", {31'd0, busy}, 32'd0);
    end

    // Single-cycle latency instance, ops issued as soon as busy falls.
    f_start = 1'b1;
    f_op    = MD_MULT;
    f_src_a = 32'd6;
    f_src_b = 32'd7;
    tick();
    f_start = 1'b0;
    check("fast mult1 busy", {31'd0, f_busy}, 32'd1);
    tick();
    check("fast mult1 busy fall", {31'd0, f_busy}, 32'd0);
    check("fast mult1 lo", f_lo, 32'd42);
    check("fast mult1 hi", f_hi, 32'd0);
    f_start = 1'b1;
    f_op    = MD_MULT;
    f_src_a = 32'hFFFFFFFF;
    f_src_b = 32'd5;
    tick();
    f_start = 1'b1;
    f_op    = MD_DIV;
    f_src_a = 32'hFFFFFFF7;
    f_src_b = 32'd4;
    check("fast mult2 busy", {31'd0, f_busy}, 32'd1);
    check("fast mult2 old lo", f_lo, 32'd42);
    tick();
    check("fast mult2 busy fall", {31'd0, f_busy}, 32'd0);
    check("fast mult2 hi", f_hi, 32'hFFFFFFFF);
    check("fast mult2 lo", f_rd_data, 32'hFFFFFFFB);
    tick();
    f_start = 1'b0;
    check("fast div busy", {31'd0, f_busy}, 32'd1);
    tick();
    check("fast div busy fall", {31'd0, f_busy}, 32'd0);
    check("fast div hi", f_hi, 32'hFFFFFFFF);
    check("fast div lo", f_lo, 32'hFFFFFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
